mem_stage: RTL and testbench

- Memory stage directly downstream of the execute stage.
- Consumes the execute result, used either as a load/store address or as a pass-through value, plus store data and destination info.
- Runs a data-memory request/response handshake and formats load data (byte-lane select, sign/zero extension).
- Presents a registered result to writeback. Stalls upstream while a memory access is outstanding.

---
 rtl/mem_stage.sv | 186 ++++++++++++++++++
 tb/tb_mem_stage.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: drives the data-memory handshake and formats load data.
// Holds upstream with stall while a request or response is outstanding.
module mem_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic [2:0]            in_funct3,
  input  logic [XLEN-1:0]       in_ex_result,
  input  logic [XLEN-1:0]       in_store_data,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic                  flush,
  output logic                  stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [XLEN-1:0]       dmem_addr,
  output logic [XLEN-1:0]       dmem_wdata,
  output logic [3:0]            dmem_wstrb,
  input  logic                  dmem_ready,
  input  logic                  dmem_rvalid,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  out_valid,
  output logic [XLEN-1:0]       out_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic                  mem_fault
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]            state;
  logic [XLEN-1:0]       addr_q;
  logic [XLEN-1:0]       sdata_q;
  logic [2:0]            f3_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  rw_q;
  logic                  st_q;
  logic                  discard_q;

  logic            is_mem;
  logic            f3_ok;
  logic            misal;
  logic            take;
  logic            hs;
  logic [3:0]      strb;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ld_val;

  assign stall = (state != S_IDLE);
  assign take  = (state == S_IDLE) && in_valid && !flush;

  always_comb begin
    is_mem = in_mem_read | in_mem_write;
    f3_ok  = 1'b0;
    if (in_mem_write)
      f3_ok = in_funct3 inside {3'd0, 3'd1, 3'd2};
    else
      f3_ok = in_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    misal = ((in_funct3[1:0] == 2'b01) && in_ex_result[0]) ||
            ((in_funct3[1:0] == 2'b10) && (in_ex_result[1:0] != 2'b00));
  end

  always_comb begin
    strb  = 4'b1111;
    wdata = sdata_q;
    unique case (f3_q[1:0])
      2'b00: begin
        strb  = 4'b0001 << addr_q[1:0];
        wdata = {4{sdata_q[7:0]}};
      end
      2'b01: begin
        strb  = 4'b0011 << addr_q[1:0];
        wdata = {2{sdata_q[15:0]}};
      end
      default: begin
        strb  = 4'b1111;
        wdata = sdata_q;
      end
    endcase
  end

  always_comb begin
    dmem_req   = (state == S_REQ);
    dmem_we    = dmem_req && st_q;
    dmem_addr  = dmem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
    dmem_wstrb = dmem_we ? strb : 4'b0000;
    dmem_wdata = dmem_we ? wdata : '0;
  end

  assign hs = dmem_req && dmem_ready;

  always_comb begin
    shifted = dmem_rdata >> {addr_q[1:0], 3'b000};
    ld_val  = '0;
    unique case (f3_q)
      3'd0:    ld_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'd1:    ld_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'd2:    ld_val = dmem_rdata;
      3'd4:    ld_val = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'd5:    ld_val = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: ld_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      sdata_q       <= '0;
      f3_q          <= 3'd0;
      rd_q          <= '0;
      rw_q          <= 1'b0;
      st_q          <= 1'b0;
      discard_q     <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      mem_fault     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      mem_fault <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (take && !is_mem) begin
            out_valid     <= 1'b1;
            out_data      <= in_ex_result;
            out_rd        <= in_rd;
            out_reg_write <= in_reg_write;
          end else if (take && (!f3_ok || misal)) begin
            mem_fault <= 1'b1;
          end else if (take) begin
            addr_q    <= in_ex_result;
            sdata_q   <= in_store_data;
            f3_q      <= in_funct3;
            rd_q      <= in_rd;
            rw_q      <= in_reg_write;
            st_q      <= in_mem_write;
            discard_q <= 1'b0;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (hs && st_q) begin
            state <= S_IDLE;
            if (!flush) begin
              out_valid     <= 1'b1;
              out_data      <= '0;
              out_rd        <= rd_q;
              out_reg_write <= 1'b0;
            end
          end else if (hs) begin
            state     <= S_WAIT;
            discard_q <= flush;
          end else if (flush) begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (dmem_rvalid) begin
            state     <= S_IDLE;
            discard_q <= 1'b0;
            if (!(discard_q || flush)) begin
              out_valid     <= 1'b1;
              out_data      <= ld_val;
              out_rd        <= rd_q;
              out_reg_write <= rw_q;
            end
          end else if (flush) begin
            discard_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus randomized ops against
// a word-array memory model with arithmetic load/store formatting.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_mem_read, in_mem_write;
  logic [2:0]  in_funct3;
  logic [31:0] in_ex_result, in_store_data;
  logic [4:0]  in_rd;
  logic        in_reg_write, flush;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_reg_write, mem_fault;

  int total = 0;
  int bad   = 0;
  logic [31:0] mem [16];

  always #5 clk = ~clk;

  mem_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_funct3(in_funct3),
    .in_ex_result(in_ex_result), .in_store_data(in_store_data),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .flush(flush),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .mem_fault(mem_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ld_exp(input logic [31:0] w,
                                         input int off, input int f3);
    longint v, b, h;
    v = longint'(w) / (longint'(1) << (8 * off));
    b = v % 256;
    h = v % 65536;
    case (f3)
      0: return 32'(b >= 128 ? b - 256 : b);
      1: return 32'(h >= 32768 ? h - 65536 : h);
      2: return w;
      4: return 32'(b);
      5: return 32'(h);
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit legal(input bit st, input int f3);
    if (st) return f3 <= 2;
    return f3 <= 2 || f3 == 4 || f3 == 5;
  endfunction

  function automatic bit aligned(input logic [31:0] a, input int f3);
    return (a % (1 << (f3 % 4))) == 0;
  endfunction

  task automatic present(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] r, input bit rw);
    in_valid = 1; in_mem_read = rd; in_mem_write = wr;
    in_funct3 = f3; in_ex_result = a; in_store_data = sd;
    in_rd = r; in_reg_write = rw;
  endtask

  task automatic idle_in();
    in_valid = 0; in_mem_read = 0; in_mem_write = 0;
  endtask

  task automatic do_alu(input logic [31:0] a, input logic [4:0] r,
                        input bit rw);
    @(negedge clk);
    present(0, 0, 3'd0, a, 32'h0, r, rw);
    chk("alu_stall", stall, 0);
    @(negedge clk);
    idle_in();
    chk("alu_valid", out_valid, 1);
    chk("alu_data", out_data, a);
    chk("alu_rd", out_rd, r);
    chk("alu_rw", out_reg_write, rw);
    chk("alu_stall2", stall, 0);
  endtask

  task automatic do_load(input logic [31:0] a, input int f3,
                         input logic [31:0] w, input int rdy_wait,
                         input int rv_wait, input logic [4:0] r);
    logic [31:0] exp;
    exp = ld_exp(w, int'(a % 4), f3);
    @(negedge clk);
    present(1, 0, 3'(f3), a, 32'h0, r, 1);
    dmem_ready = 0;
    @(negedge clk);
    chk("ld_stall", stall, 1);
    chk("ld_req", dmem_req, 1);
    chk("ld_we", dmem_we, 0);
    chk("ld_addr", dmem_addr, a & 32'hFFFF_FFFC);
    chk("ld_strb", dmem_wstrb, 0);
    for (int i = 0; i < rdy_wait; i++) begin
      @(negedge clk);
      chk("ld_req_hold", dmem_req, 1);
      chk("ld_addr_hold", dmem_addr, a & 32'hFFFF_FFFC);
    end
    dmem_ready = 1;
    @(negedge clk);
    dmem_ready = 0;
    chk("ld_wait_req", dmem_req, 0);
    chk("ld_wait_stall", stall, 1);
    chk("ld_wait_valid", out_valid, 0);
    for (int i = 0; i < rv_wait; i++) begin
      @(negedge clk);
      chk("ld_wait_stall", stall, 1);
    end
    dmem_rvalid = 1;
    dmem_rdata = w;
    idle_in();
    @(negedge clk);
    dmem_rvalid = 0;
    chk("ld_valid", out_valid, 1);
    chk("ld_data", out_data, exp);
    chk("ld_rd", out_rd, r);
    chk("ld_rw", out_reg_write, 1);
    chk("ld_done_stall", stall, 0);
  endtask

  task automatic do_store(input logic [31:0] a, input int f3,
                          input logic [31:0] d, input int rdy_wait);
    logic [3:0]  es;
    logic [31:0] ew;
    int          off;
    int          idx;
    off = int'(a % 4);
    idx = int'((a / 4) % 16);
    case (f3)
      0: begin es = 4'(1 << off); ew = (d % 256) * 32'h0101_0101; end
      1: begin es = 4'(3 << off); ew = (d % 65536) * 32'h0001_0001; end
      default: begin es = 4'hF; ew = d; end
    endcase
    @(negedge clk);
    present(0, 1, 3'(f3), a, d, 5'd0, 0);
    dmem_ready = 0;
    for (int i = 0; i <= rdy_wait; i++) begin
      @(negedge clk);
      chk("st_req", dmem_req, 1);
      chk("st_we", dmem_we, 1);
      chk("st_addr", dmem_addr, a & 32'hFFFF_FFFC);
      chk("st_strb", dmem_wstrb, es);
      chk("st_wdata", dmem_wdata, ew);
      chk("st_stall", stall, 1);
    end
    dmem_ready = 1;
    idle_in();
    @(negedge clk);
    dmem_ready = 0;
    for (int i = 0; i < 4; i++)
      if (es[i]) mem[idx][8*i +: 8] = ew[8*i +: 8];
    chk("st_valid", out_valid, 1);
    chk("st_rw", out_reg_write, 0);
    chk("st_data", out_data, 0);
    chk("st_done_stall", stall, 0);
  endtask

  task automatic do_fault(input bit wr, input logic [31:0] a, input int f3);
    @(negedge clk);
    present(!wr, wr, 3'(f3), a, 32'h1234_5678, 5'd7, 1);
    @(negedge clk);
    idle_in();
    chk("flt_pulse", mem_fault, 1);
    chk("flt_valid", out_valid, 0);
    chk("flt_req", dmem_req, 0);
    chk("flt_stall", stall, 0);
    @(negedge clk);
    chk("flt_end", mem_fault, 0);
  endtask

  initial begin
    reset = 1; flush = 0;
    in_valid = 0; in_mem_read = 0; in_mem_write = 0;
    in_funct3 = 0; in_ex_result = 0; in_store_data = 0;
    in_rd = 0; in_reg_write = 0;
    dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_rd", out_rd, 0);
    chk("rst_rw", out_reg_write, 0);
    chk("rst_fault", mem_fault, 0);
    chk("rst_stall", stall, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_addr", dmem_addr, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;

    do_alu(32'h0000_1234, 5'd5, 1);
    do_load(32'h103, 0, 32'h80FF_0011, 0, 1, 5'd6);
    chk("lb_const", out_data, 32'hFFFF_FF80);
    do_load(32'h202, 5, 32'hBEEF_0000, 0, 0, 5'd7);
    chk("lhu_const", out_data, 32'h0000_BEEF);
    do_load(32'h200, 2, 32'hDEAD_BEEF, 1, 0, 5'd8);
    chk("lw_const", out_data, 32'hDEAD_BEEF);
    do_store(32'h301, 0, 32'h0000_00AB, 3);
    do_fault(0, 32'h402, 2);
    do_fault(1, 32'h405, 1);
    do_fault(0, 32'h400, 3);
    do_fault(1, 32'h400, 4);

    // flush in IDLE: a misaligned op is dropped without a fault
    @(negedge clk);
    present(1, 0, 3'd2, 32'h402, 0, 5'd3, 1);
    flush = 1;
    @(negedge clk);
    flush = 0;
    idle_in();
    chk("fidle_valid", out_valid, 0);
    chk("fidle_fault", mem_fault, 0);
    chk("fidle_stall", stall, 0);

    // flush in REQ before acceptance aborts
    @(negedge clk);
    present(1, 0, 3'd2, 32'h200, 0, 5'd3, 1);
    dmem_ready = 0;
    @(negedge clk);
    chk("freq_req", dmem_req, 1);
    flush = 1;
    idle_in();
    @(negedge clk);
    flush = 0;
    chk("freq_req0", dmem_req, 0);
    chk("freq_stall", stall, 0);
    chk("freq_valid", out_valid, 0);

    // flush in WAIT discards the returning word
    @(negedge clk);
    present(1, 0, 3'd2, 32'h200, 0, 5'd3, 1);
    @(negedge clk);
    dmem_ready = 1;
    idle_in();
    @(negedge clk);
    dmem_ready = 0;
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("fwait_stall", stall, 1);
    dmem_rvalid = 1;
    dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    dmem_rvalid = 0;
    chk("fwait_valid", out_valid, 0);
    chk("fwait_stall0", stall, 0);
    do_alu(32'h0000_0042, 5'd9, 1);

    // flush in the load handshake cycle
    @(negedge clk);
    present(1, 0, 3'd2, 32'h204, 0, 5'd3, 1);
    @(negedge clk);
    dmem_ready = 1;
    flush = 1;
    idle_in();
    @(negedge clk);
    dmem_ready = 0;
    flush = 0;
    chk("fhs_ld_stall", stall, 1);
    dmem_rvalid = 1;
    @(negedge clk);
    dmem_rvalid = 0;
    chk("fhs_ld_valid", out_valid, 0);

    // flush in the store handshake cycle: write lands, no writeback
    @(negedge clk);
    present(0, 1, 3'd2, 32'h200, 32'hCAFE_F00D, 5'd0, 0);
    @(negedge clk);
    dmem_ready = 1;
    flush = 1;
    idle_in();
    @(negedge clk);
    dmem_ready = 0;
    flush = 0;
    mem[0] = 32'hCAFE_F00D;
    chk("fhs_st_valid", out_valid, 0);
    chk("fhs_st_stall", stall, 0);

    for (int n = 0; n < 60; n++) begin
      int          kind, f3;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      f3 = $urandom_range(0, 7);
      a = 32'($urandom_range(0, 63));
      if (kind == 0)
        do_alu($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      else if (kind == 1 && legal(0, f3) && aligned(a, f3))
        do_load(a, f3, mem[a / 4], $urandom_range(0, 2),
                $urandom_range(0, 2), 5'($urandom_range(0, 31)));
      else if (kind == 2 && legal(1, f3) && aligned(a, f3))
        do_store(a, f3, $urandom, $urandom_range(0, 2));
      else
        do_fault(kind == 2, a, f3);
    end

    // asynchronous reset while a request is pending
    do_alu(32'h0000_5555, 5'd4, 1);
    @(negedge clk);
    present(1, 0, 3'd2, 32'h200, 0, 5'd3, 1);
    @(negedge clk);
    idle_in();
    chk("arst_pre_req", dmem_req, 1);
    #2 reset = 1;
    #1;
    chk("arst_req", dmem_req, 0);
    chk("arst_addr", dmem_addr, 0);
    chk("arst_stall", stall, 0);
    chk("arst_data", out_data, 0);
    chk("arst_rd", out_rd, 0);
    chk("arst_rw", out_reg_write, 0);
    dmem_rvalid = 1;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    dmem_rvalid = 0;
    chk("arst_ignore", out_valid, 0);
    chk("arst_idle", stall, 0);
    do_alu(32'h0000_0077, 5'd2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
